wallace_pipe_mac: RTL and testbench

WALLACE_PIPE_MAC -- requirements
Module: wallace_pipe_mac

---
 rtl/wallace_pkg.sv | 51 +++++
 rtl/wallace_csa_row.sv | 18 +
 rtl/wallace_pipe_mac.sv | 165 ++++++++++++++++
 tb/tb_wallace_pipe_mac.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/wallace_pkg.sv
// Mode encoding and tree-shape helpers shared by the Wallace-tree MAC.
package wallace_pkg;

    typedef enum logic [1:0] {
        MODE_UMUL = 2'b00,
        MODE_SMUL = 2'b01,
        MODE_SMAC = 2'b10,
        MODE_CLR  = 2'b11
    } mode_t;

    // Rows left after one layer: 3:2 groups, a 2:2 on a leftover pair, a lone row passes.
    function automatic int unsigned next_rows(input int unsigned n);
        return 2 * (n / 3) + (n % 3);
    endfunction

    // Rows entering a layer; layer 0 sees WIDTH rows plus two sign-correction rows.
    function automatic int unsigned rows_at(input int unsigned width, input int unsigned layer);
        int unsigned n;
        n = width + 2;
        for (int unsigned i = 0; i < layer; i++) begin
            n = next_rows(n);
        end
        return n;
    endfunction

    function automatic int unsigned tree_layers(input int unsigned width);
        int unsigned n;
        int unsigned l;
        n = width + 2;
        l = 0;
        while (n > 2) begin
            n = next_rows(n);
            l++;
        end
        return l;
    endfunction

    // Internal register k (1..stages-2) sits in front of this layer; 0 means no register.
    function automatic int unsigned cut_idx(input int unsigned layer, input int unsigned layers,
                                            input int unsigned stages);
        int unsigned res;
        res = 0;
        for (int unsigned k = 1; k + 2 <= stages; k++) begin
            if ((k * (layers + 1)) / (stages - 1) == layer) begin
                res = k;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/wallace_csa_row.sv
// One row of 3:2 carry-save compressors; carry is pre-shifted to its weight and truncated.
module wallace_csa_row #(
    parameter int unsigned W = 16
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic [W-1:0] z,
    output logic [W-1:0] s,
    output logic [W-1:0] c
);

    logic [W-2:0] maj;

    assign s   = x ^ y ^ z;
    assign maj = (x[W-2:0] & y[W-2:0]) | (x[W-2:0] & z[W-2:0]) | (y[W-2:0] & z[W-2:0]);
    assign c   = {maj, 1'b0};

endmodule

// File: rtl/wallace_pipe_mac.sv
// Pipelined Wallace-tree multiplier with signed/unsigned modes and a wrapping accumulator.
module wallace_pipe_mac
    import wallace_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned STAGES    = 3,
    parameter int unsigned ACC_GUARD = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             a,
    input  logic [WIDTH-1:0]             b,
    input  logic [1:0]                   mode,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [2*WIDTH-1:0]           p,
    output logic [2*WIDTH+ACC_GUARD-1:0] acc
);

    localparam int unsigned W  = WIDTH;
    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned AW = PW + ACC_GUARD;
    localparam int unsigned S  = STAGES;
    localparam int unsigned L  = tree_layers(WIDTH);
    localparam int unsigned NR = W + 2;

    logic          adv;
    logic [S-1:0]  v_q;
    mode_t         m_q [S];
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic          sa;
    logic          sb;
    logic [PW-1:0] a_sx;
    logic [PW-1:0] pp [NR];
    logic [PW-1:0] sum_c;
    logic [AW-1:0] acc_q;

    // A full output register with no taker freezes the whole pipe.
    assign adv       = !(out_valid && !out_ready);
    assign in_ready  = adv;
    assign out_valid = v_q[S-1];
    assign acc       = acc_q;

    // Operand capture plus valid/mode shift chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q <= '0;
            a_q <= '0;
            b_q <= '0;
            for (int unsigned s = 0; s < S; s++) begin
                m_q[s] <= MODE_UMUL;
            end
        end else if (adv) begin
            v_q[0] <= in_valid;
            m_q[0] <= mode_t'(mode);
            a_q    <= (mode == MODE_CLR) ? '0 : a;
            b_q    <= (mode == MODE_CLR) ? '0 : b;
            for (int unsigned s = 1; s < S; s++) begin
                v_q[s] <= v_q[s-1];
                m_q[s] <= m_q[s-1];
            end
        end
    end

    // Operands are treated as WIDTH+1-bit two's complement; the top multiplier bit has
    // negative weight, so its row is complemented and a +1 row is added at that weight.
    assign sa   = (m_q[0] != MODE_UMUL) && a_q[W-1];
    assign sb   = (m_q[0] != MODE_UMUL) && b_q[W-1];
    assign a_sx = {{(PW - W){sa}}, a_q};

    always_comb begin
        for (int unsigned i = 0; i < W; i++) begin
            pp[i] = b_q[i] ? (a_sx << i) : '0;
        end
        pp[W]   = sb ? ((~a_sx) << W) : '0;
        pp[W+1] = sb ? (PW'(1) << W) : '0;
    end

    // Tree levels; some levels are registered to spread the layers over the stages.
    for (genvar l = 0; l <= L; l++) begin : g_lv
        localparam int unsigned N = rows_at(W, l);
        logic [PW-1:0] src [N];
        logic [PW-1:0] cur [N];

        if (l == 0) begin : g_pp
            for (genvar r = 0; r < N; r++) begin : g_r
                assign src[r] = pp[r];
            end
        end else begin : g_tree
            localparam int unsigned NP = rows_at(W, l - 1);
            localparam int unsigned G  = NP / 3;
            for (genvar g = 0; g < G; g++) begin : g_csa
                wallace_csa_row #(.W(PW)) u_csa (
                    .x (g_lv[l-1].cur[3*g]),
                    .y (g_lv[l-1].cur[3*g+1]),
                    .z (g_lv[l-1].cur[3*g+2]),
                    .s (src[2*g]),
                    .c (src[2*g+1])
                );
            end
            if (NP % 3 == 2) begin : g_half
                wallace_csa_row #(.W(PW)) u_ha (
                    .x (g_lv[l-1].cur[NP-2]),
                    .y (g_lv[l-1].cur[NP-1]),
                    .z ('0),
                    .s (src[2*G]),
                    .c (src[2*G+1])
                );
            end else if (NP % 3 == 1) begin : g_pass
                assign src[2*G] = g_lv[l-1].cur[NP-1];
            end
        end

        if (cut_idx(l, L, S) != 0) begin : g_cut
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int unsigned r = 0; r < N; r++) begin
                        cur[r] <= '0;
                    end
                end else if (adv) begin
                    for (int unsigned r = 0; r < N; r++) begin
                        cur[r] <= src[r];
                    end
                end
            end
        end else begin : g_comb
            for (genvar r = 0; r < N; r++) begin : g_r
                assign cur[r] = src[r];
            end
        end
    end

    assign sum_c = g_lv[L].cur[0] + g_lv[L].cur[1];

    if (S > 1) begin : g_preg
        logic [PW-1:0] p_q;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                p_q <= '0;
            end else if (adv) begin
                p_q <= sum_c;
            end
        end
        assign p = p_q;
    end else begin : g_pcomb
        assign p = sum_c;
    end

    // Accumulator acts only on the output handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else if (out_valid && out_ready) begin
            if (m_q[S-1] == MODE_SMAC) begin
                acc_q <= acc_q + AW'($signed(p));
            end else if (m_q[S-1] == MODE_CLR) begin
                acc_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_wallace_pipe_mac.sv
// Directed checks of wallace_pipe_mac: default 32-bit/3-stage instance and an 8-bit/6-stage one.
module tb_wallace_pipe_mac;

    logic        clk;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] a, b;
    logic [1:0]  mode;
    logic [63:0] p;
    logic [71:0] acc;

    logic        in_valid8, in_ready8, out_valid8, out_ready8;
    logic [7:0]  a8, b8;
    logic [1:0]  mode8;
    logic [15:0] p8;
    logic [19:0] acc8;

    int n_tests = 0;
    int n_fail  = 0;

    wallace_pipe_mac dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
        .p(p), .acc(acc)
    );

    wallace_pipe_mac #(.WIDTH(8), .STAGES(6), .ACC_GUARD(4)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .mode(mode8), .out_valid(out_valid8), .out_ready(out_ready8),
        .p(p8), .acc(acc8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transaction with an always-ready consumer; returns after its output handshake edge.
    task automatic xact(input string tag, input logic [1:0] md, input logic [31:0] aa,
                        input logic [31:0] bb, input logic [63:0] ep);
        int n;
        mode = md; a = aa; b = bb; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_lat"}, 128'(n), 128'(3));
        check(tag, p, ep);
        tick();
    endtask

    logic [63:0] ex_tp [4]  = '{64'd2, 64'd6, 64'd12, 64'd20};
    logic [1:0]  md8t [7]   = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b11, 2'b10};
    logic [7:0]  a8t  [7]   = '{8'hFF, 8'h80, 8'h80, 8'hFD, 8'h07, 8'h12, 8'h80};
    logic [7:0]  b8t  [7]   = '{8'hFF, 8'h80, 8'h7F, 8'h05, 8'h09, 8'h34, 8'h80};
    logic [15:0] ep8  [7]   = '{16'hFE01, 16'h4000, 16'hC080, 16'hFFF1, 16'h003F, 16'h0000, 16'h4000};
    logic [19:0] ea8  [7]   = '{20'h0, 20'h0, 20'h0, 20'hFFFF1, 20'h00030, 20'h00000, 20'h04000};
    logic [7:0]  rdy_pat    = 8'b1011_0110;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int seen;
        int tx, rx, cyc;
        logic pend, take;

        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; mode = 2'b00;
        in_valid8 = 1'b0; out_ready8 = 1'b1; a8 = '0; b8 = '0; mode8 = 2'b00;
        #1 rst = 1'b1;
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_acc", acc, 0);
        check("rst_p", p, 0);
        check("rst_in_ready", in_ready, 1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Basic products, extremes and accumulator modes
        xact("umul", 2'b00, 32'd19, 32'd15, 64'd285);
        xact("smul_neg", 2'b01, 32'hFFFFFFFB, 32'd10, 64'hFFFFFFFFFFFFFFCE);
        xact("smul_min", 2'b01, 32'h80000000, 32'h80000000, 64'h4000000000000000);
        xact("umul_max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001);
        check("acc_idle", acc, 0);
        xact("clr", 2'b11, 32'd7, 32'd9, 64'd0);
        check("acc_clr", acc, 0);
        xact("mac1", 2'b10, 32'd3, 32'd4, 64'd12);
        check("acc_mac1", acc, 72'd12);
        xact("mac2", 2'b10, 32'hFFFFFFFE, 32'd7, 64'hFFFFFFFFFFFFFFF2);
        check("acc_mac2", acc, 72'hFFFFFFFFFFFFFFFFFE);
        xact("mac3", 2'b10, 32'd100, 32'd100, 64'd10000);
        check("acc_mac3", acc, 72'd9998);
        xact("smul_keep", 2'b01, 32'd6, 32'd7, 64'd42);
        check("acc_keep", acc, 72'd9998);

        // Full-rate stream: one result per cycle
        mode = 2'b00; out_ready = 1'b1;
        for (int t = 0; t < 6; t++) begin
            in_valid = (t < 4);
            a = 32'(t + 1);
            b = 32'(t + 2);
            tick();
            if (t >= 2) begin
                check("stream_valid", out_valid, 1);
                check("stream_p", p, ex_tp[t-2]);
            end
        end
        in_valid = 1'b0;
        tick();

        // Output stall with two results in flight
        out_ready = 1'b0; mode = 2'b00;
        a = 32'd9943000; b = 32'd3302367; in_valid = 1'b1;
        tick();
        a = 32'd5; b = 32'd10;
        tick();
        in_valid = 1'b0;
        tick();
        check("stall_valid", out_valid, 1);
        check("stall_p", p, 64'd32835435081000);
        check("stall_in_ready", in_ready, 0);
        a = 32'd1; b = 32'd1; in_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            check("stall_hold_valid", out_valid, 1);
            check("stall_hold_p", p, 64'd32835435081000);
            check("stall_hold_rdy", in_ready, 0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        check("stall_next_valid", out_valid, 1);
        check("stall_next_p", p, 64'd50);
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (out_valid) seen++;
        end
        check("stall_no_dup", 128'(seen), 0);

        // Asynchronous reset with three MACs in flight
        out_ready = 1'b0; mode = 2'b10; in_valid = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            a = 32'(k); b = 32'(k);
            tick();
        end
        in_valid = 1'b0;
        check("pre_rst_valid", out_valid, 1);
        #3 rst = 1'b1;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_acc", acc, 0);
        check("arst_p", p, 0);
        check("arst_in_ready", in_ready, 1);
        @(posedge clk);
        #3 rst = 1'b0; out_ready = 1'b1;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (out_valid) seen++;
        end
        check("arst_no_stale", 128'(seen), 0);
        check("arst_acc_after", acc, 0);
        xact("post_rst", 2'b00, 32'd6, 32'd9, 64'd54);

        // 8-bit, 6-stage instance with an irregular consumer
        tx = 0; rx = 0; cyc = 0; pend = 1'b0;
        while (rx < 7 && cyc < 200) begin
            if (pend) begin
                check("w8_acc", acc8, ea8[rx]);
                rx++;
                pend = 1'b0;
            end
            out_ready8 = rdy_pat[cyc % 8];
            in_valid8  = (tx < 7);
            if (tx < 7) begin
                mode8 = md8t[tx]; a8 = a8t[tx]; b8 = b8t[tx];
            end
            #1;
            if (out_valid8 && out_ready8) begin
                if (rx < 7) begin
                    check("w8_p", p8, ep8[rx]);
                    pend = 1'b1;
                end else begin
                    check("w8_extra", 1, 0);
                end
            end
            take = in_valid8 && in_ready8;
            @(posedge clk);
            #1;
            if (take) tx++;
            cyc++;
        end
        check("w8_done", 128'(rx), 7);
        in_valid8 = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
